// File: rtl/usb_hid_pkg.sv
// rtl/usb_hid_pkg.sv - shared constants and FSM encoding for the HID keyboard report source
package usb_hid_pkg;

    localparam int REPORT_BYTES = 8;

    // Modifier byte bit positions
    localparam int MOD_LCTRL  = 0;
    localparam int MOD_LSHIFT = 1;
    localparam int MOD_LALT   = 2;
    localparam int MOD_LGUI   = 3;
    localparam int MOD_RCTRL  = 4;
    localparam int MOD_RSHIFT = 5;
    localparam int MOD_RALT   = 6;
    localparam int MOD_RGUI   = 7;

    // Common usage codes
    localparam logic [7:0] KEY_A     = 8'h04;
    localparam logic [7:0] KEY_ENTER = 8'h28;

    // Host LED output report bit positions
    localparam int LED_NUM     = 0;
    localparam int LED_CAPS    = 1;
    localparam int LED_SCROLL  = 2;
    localparam int LED_COMPOSE = 3;
    localparam int LED_KANA    = 4;
    localparam int LED_BITS    = 5;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESS   = 2'd1,
        ST_RELEASE = 2'd2
    } kbd_state_e;

endpackage

// File: rtl/usb_hid_req_fifo.sv
// rtl/usb_hid_req_fifo.sv - request FIFO with registered writes, async reset, sync flush and level
module usb_hid_req_fifo #(
    parameter int WIDTH = 56,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       push_data_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       head_o,
    output logic [$clog2(DEPTH):0] level_o,
    output logic                   full_o,
    output logic                   empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      level_q;
    logic [AW:0]      level_d;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (level_q == (AW+1)'(DEPTH));
    assign empty_o = (level_q == '0);
    assign push_ok = push_i & ~full_o & ~flush_i;
    assign pop_ok  = pop_i & ~empty_o & ~flush_i;
    assign head_o  = mem_q[rd_ptr_q];
    assign level_o = level_q;

    // Occupancy next state: a simultaneous push and pop cancel out
    always_comb begin
        level_d = level_q;
        if (push_ok && !pop_ok) begin
            level_d = level_q + (AW+1)'(1);
        end else if (pop_ok && !push_ok) begin
            level_d = level_q - (AW+1)'(1);
        end
    end

    // Storage array; contents need no reset because level gates visibility
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // Pointers and level; flush empties the FIFO in one cycle
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            level_q <= level_d;
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
        end
    end

endmodule

// File: rtl/usb_hid_kbd_report_gen.sv
// rtl/usb_hid_kbd_report_gen.sv - boot-protocol keyboard report source for EP81; USB_KBD_LED_EN adds EP01 LED capture
module usb_hid_kbd_report_gen
    import usb_hid_pkg::*;
#(
    parameter int NKEYS        = 6,
    parameter int FIFO_DEPTH   = 8,
    parameter int AUTO_RELEASE = 1
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        usb_online,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic [7:0]                  req_modifier,
    input  logic [8*NKEYS-1:0]          req_keys,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic [7:0]                  ep81_data,
    output logic                        ep81_valid,
    input  logic                        ep81_ready,
    output logic [15:0]                 reports_sent,
    input  logic [7:0]                  ep01_data,
    input  logic                        ep01_valid,
    output logic [4:0]                  led_state
);

    localparam int          ENTRY_W   = 8 + 8 * NKEYS;
    localparam logic [2:0]  LAST_BYTE = 3'(REPORT_BYTES - 1);

    kbd_state_e       state_q;
    logic [2:0]       cnt_q;
    logic             valid_q;
    logic [7:0]       data_q;
    logic [15:0]      sent_q;
    logic [7:0]       rpt_q    [REPORT_BYTES];
    logic [7:0]       head_rpt [REPORT_BYTES];

    logic [ENTRY_W-1:0] head_entry;
    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_pop;
    logic               byte_done;

    // Requests are refused in reset, while offline, and when the FIFO is full
    assign req_ready = rstn & usb_online & ~fifo_full;
    assign fifo_pop  = (state_q == ST_IDLE) & ~fifo_empty & usb_online;
    assign byte_done = valid_q & ep81_ready;

    usb_hid_req_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_req_fifo (
        .clk         (clk),
        .rstn        (rstn),
        .flush_i     (~usb_online),
        .push_i      (req_valid & req_ready),
        .push_data_i ({req_keys, req_modifier}),
        .pop_i       (fifo_pop),
        .head_o      (head_entry),
        .level_o     (fifo_level),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    // Lay the FIFO head out as a boot report: modifier, reserved, keys, zero padding
    always_comb begin
        head_rpt    = '{default: 8'h00};
        head_rpt[0] = head_entry[7:0];
        for (int i = 0; i < NKEYS; i++) begin
            head_rpt[2+i] = head_entry[8+8*i +: 8];
        end
    end

    // Report FSM with registered stream outputs and report counter
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            sent_q  <= '0;
            rpt_q   <= '{default: 8'h00};
        end else if (!usb_online) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            sent_q  <= '0;
        end else begin
            if (byte_done && cnt_q == LAST_BYTE) begin
                sent_q <= sent_q + 16'd1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        rpt_q   <= head_rpt;
                        data_q  <= head_rpt[0];
                        valid_q <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= ST_PRESS;
                    end
                end
                ST_PRESS: begin
                    if (ep81_ready) begin
                        if (cnt_q == LAST_BYTE) begin
                            cnt_q  <= '0;
                            data_q <= 8'h00;
                            if (AUTO_RELEASE != 0) begin
                                state_q <= ST_RELEASE;
                            end else begin
                                state_q <= ST_IDLE;
                                valid_q <= 1'b0;
                            end
                        end else begin
                            cnt_q  <= cnt_q + 3'd1;
                            data_q <= rpt_q[cnt_q + 3'd1];
                        end
                    end
                end
                ST_RELEASE: begin
                    if (ep81_ready) begin
                        if (cnt_q == LAST_BYTE) begin
                            cnt_q   <= '0;
                            valid_q <= 1'b0;
                            state_q <= ST_IDLE;
                        end else begin
                            cnt_q <= cnt_q + 3'd1;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    valid_q <= 1'b0;
                    data_q  <= '0;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign ep81_valid   = valid_q;
    assign ep81_data    = data_q;
    assign reports_sent = sent_q;

`ifdef USB_KBD_LED_EN
    logic [LED_BITS-1:0] led_q;
    logic [2:0]          unused_ep01_hi;

    assign unused_ep01_hi = ep01_data[7:5];

    // Latch host LED output reports; the most recent strobe wins
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            led_q <= '0;
        end else if (!usb_online) begin
            led_q <= '0;
        end else if (ep01_valid) begin
            led_q <= ep01_data[LED_BITS-1:0];
        end
    end

    assign led_state = led_q;
`else
    logic unused_ep01;

    assign unused_ep01 = ^{ep01_data, ep01_valid};
    assign led_state   = '0;
`endif

endmodule

// File: tb/tb_usb_hid_kbd_report_gen.sv
// tb/tb_usb_hid_kbd_report_gen.sv - directed self-checking bench for usb_hid_kbd_report_gen
module tb_usb_hid_kbd_report_gen;

    logic        clk = 1'b0;
    logic        rstn;
    logic        usb_online;

    logic        req_valid;
    logic        req_ready;
    logic [7:0]  req_modifier;
    logic [47:0] req_keys;
    logic [3:0]  fifo_level;
    logic [7:0]  ep81_data;
    logic        ep81_valid;
    logic        ep81_ready;
    logic [15:0] reports_sent;
    logic [7:0]  ep01_data;
    logic        ep01_valid;
    logic [4:0]  led_state;

    logic        req_valid2;
    logic        req_ready2;
    logic [7:0]  req_modifier2;
    logic [15:0] req_keys2;
    logic [2:0]  fifo_level2;
    logic [7:0]  ep81_data2;
    logic        ep81_valid2;
    logic        ep81_ready2;
    logic [15:0] reports_sent2;
    logic [4:0]  led_state2;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] exp_q [$];
    logic [7:0] e2 [8] = '{8'h00, 8'h00, 8'h04, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00};

    always #5 clk = ~clk;

    usb_hid_kbd_report_gen #(.NKEYS(6), .FIFO_DEPTH(8), .AUTO_RELEASE(1)) dut (
        .clk (clk), .rstn (rstn), .usb_online (usb_online),
        .req_valid (req_valid), .req_ready (req_ready),
        .req_modifier (req_modifier), .req_keys (req_keys),
        .fifo_level (fifo_level),
        .ep81_data (ep81_data), .ep81_valid (ep81_valid), .ep81_ready (ep81_ready),
        .reports_sent (reports_sent),
        .ep01_data (ep01_data), .ep01_valid (ep01_valid), .led_state (led_state)
    );

    usb_hid_kbd_report_gen #(.NKEYS(2), .FIFO_DEPTH(4), .AUTO_RELEASE(0)) dut2 (
        .clk (clk), .rstn (rstn), .usb_online (usb_online),
        .req_valid (req_valid2), .req_ready (req_ready2),
        .req_modifier (req_modifier2), .req_keys (req_keys2),
        .fifo_level (fifo_level2),
        .ep81_data (ep81_data2), .ep81_valid (ep81_valid2), .ep81_ready (ep81_ready2),
        .reports_sent (reports_sent2),
        .ep01_data (8'h00), .ep01_valid (1'b0), .led_state (led_state2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_req(input logic [7:0] m, input logic [47:0] k, output bit ok);
        req_modifier = m;
        req_keys     = k;
        req_valid    = 1'b1;
        ok           = req_ready;
        step();
        req_valid    = 1'b0;
    endtask

    task automatic collect(input int pct, input int bound);
        int   idx;
        int   cyc;
        logic r;
        idx = 0;
        cyc = 0;
        while (idx < exp_q.size() && cyc < bound) begin
            r = ($urandom_range(99) < pct);
            if (ep81_valid) begin
                check("stream_byte", {24'h0, ep81_data}, {24'h0, exp_q[idx]});
            end
            ep81_ready = r;
            if (ep81_valid && r) idx++;
            step();
            cyc++;
        end
        ep81_ready = 1'b0;
        check("stream_done", idx, exp_q.size());
    endtask

    initial begin
        bit ok;
        int acc;
        int cyc;

        rstn = 1'b0; usb_online = 1'b1;
        req_valid = 1'b0; req_modifier = '0; req_keys = '0; ep81_ready = 1'b0;
        ep01_data = '0; ep01_valid = 1'b0;
        req_valid2 = 1'b0; req_modifier2 = '0; req_keys2 = '0; ep81_ready2 = 1'b1;
        step(); step();
        check("rst_req_ready", req_ready, 0);
        check("rst_fifo_level", fifo_level, 0);
        check("rst_valid", ep81_valid, 0);
        check("rst_data", ep81_data, 0);
        check("rst_sent", reports_sent, 0);
        check("rst_led", led_state, 0);
        check("rst_req_ready2", req_ready2, 0);
        rstn = 1'b1;
        step();
        check("online_req_ready", req_ready, 1);

        // Single press/release pair with 2-cycle latency and continuous valid
        push_req(8'h02, 48'h04, ok);
        check("t1_accept", ok, 1);
        check("t1_level", fifo_level, 1);
        check("t1_valid_early", ep81_valid, 0);
        step();
        step();
        check("t1_valid_lat", ep81_valid, 1);
        exp_q = '{8'h02, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                  8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        for (int k = 0; k < 16; k++) begin
            check("t1_valid_cont", ep81_valid, 1);
            check("t1_byte", ep81_data, exp_q[k]);
            ep81_ready = 1'b1;
            step();
        end
        ep81_ready = 1'b0;
        check("t1_valid_end", ep81_valid, 0);
        check("t1_sent", reports_sent, 2);

        // Random 30% ready: bytes hold until consumed, none skipped
        push_req(8'h11, 48'h090807060504, ok);
        check("t3_accept", ok, 1);
        exp_q = '{8'h11, 8'h00, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09,
                  8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        collect(30, 600);
        check("t3_sent", reports_sent, 4);

        // Fill the FIFO with ep81_ready low
        acc = 0;
        for (int i = 0; i < 10; i++) begin
            push_req(8'(i), 48'(8'h10 + i), ok);
            if (!ok) break;
            acc++;
            if (acc == 8) check("t2_level7", fifo_level, 7);
        end
        check("t2_accepted", acc, 9);
        check("t2_level_full", fifo_level, 8);
        check("t2_ready_full", req_ready, 0);
        step(); step();
        check("t2_level_hold", fifo_level, 8);
        exp_q = {};
        for (int p = 0; p < 9; p++) begin
            exp_q.push_back(8'(p));
            exp_q.push_back(8'h00);
            exp_q.push_back(8'(8'h10 + p));
            for (int b = 3; b < 16; b++) exp_q.push_back(8'h00);
        end
        collect(60, 1200);
        check("t2_level_empty", fifo_level, 0);
        check("t2_sent", reports_sent, 22);

        // Go offline mid-report with three requests queued
        push_req(8'h01, 48'h3304, ok);
        push_req(8'h02, 48'h05, ok);
        push_req(8'h03, 48'h06, ok);
        push_req(8'h04, 48'h07, ok);
        check("t5_level", fifo_level, 3);
        ep81_ready = 1'b1;
        step(); step(); step();
        ep81_ready = 1'b0;
        check("t5_byte3", ep81_data, 8'h33);
        check("t5_sent_before", reports_sent, 22);
        usb_online = 1'b0;
        #1;
        check("t5_ready_off", req_ready, 0);
        step();
        check("t5_valid_off", ep81_valid, 0);
        check("t5_level_off", fifo_level, 0);
        check("t5_sent_off", reports_sent, 0);
        step();
        check("t5_valid_off2", ep81_valid, 0);
        usb_online = 1'b1;
        step();
        push_req(8'h20, 48'h28, ok);
        check("t5_accept", ok, 1);
        exp_q = '{8'h20, 8'h00, 8'h28, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                  8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        collect(100, 100);
        check("t5_sent_after", reports_sent, 2);
        check("t5_level_after", fifo_level, 0);

        // Host LED output bytes
        ep01_data = 8'h03; ep01_valid = 1'b1;
        step();
        ep01_data = 8'h02;
        step();
        ep01_valid = 1'b0; ep01_data = 8'h1F;
        step();
`ifdef USB_KBD_LED_EN
        check("led_last", led_state, 5'h02);
`else
        check("led_last", led_state, 5'h00);
`endif

        // Two-key instance without auto-release
        req_modifier2 = 8'h00; req_keys2 = 16'h0504; req_valid2 = 1'b1;
        check("t6_ready", req_ready2, 1);
        step();
        req_valid2 = 1'b0;
        cyc = 0;
        while (!ep81_valid2 && cyc < 10) begin
            step();
            cyc++;
        end
        check("t6_valid_seen", ep81_valid2, 1);
        for (int k = 0; k < 8; k++) begin
            check("t6_valid_cont", ep81_valid2, 1);
            check("t6_byte", ep81_data2, e2[k]);
            step();
        end
        check("t6_valid_end", ep81_valid2, 0);
        step();
        check("t6_valid_end2", ep81_valid2, 0);
        check("t6_sent", reports_sent2, 1);
        check("t6_led", led_state2, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
